// File: rtl/counter_pkg.sv
// Shared constants for the down-counter family.
// Default width and underflow-mode encodings.
package counter_pkg;

    localparam int   CNT_WIDTH   = 4;
    localparam logic MODE_WRAP   = 1'b0;
    localparam logic MODE_RELOAD = 1'b1;

endpackage

// File: rtl/down_counter_4bit.sv
// Loadable down counter with wrap or auto-reload on underflow.
// Registered one-cycle tc pulse per underflow; bo flags zero.
module down_counter_4bit
    import counter_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ld,
    input  logic [WIDTH-1:0] din,
    input  logic             mode,
    output logic             bo,
    output logic             tc,
    output logic [WIDTH-1:0] counter
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] underflow_val;
    logic             at_zero;

    assign at_zero = (counter == '0);
    assign bo      = at_zero;

    always_comb begin
        underflow_val = '1;
        unique case (mode)
            MODE_RELOAD: underflow_val = reload_q;
            MODE_WRAP:   underflow_val = '1;
            default:     underflow_val = '1;
        endcase
    end

    // Priority: reset > load > count > hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            counter  <= '0;
            reload_q <= '0;
            tc       <= 1'b0;
        end else if (ld) begin
            counter  <= din;
            reload_q <= din;
            tc       <= 1'b0;
        end else if (en) begin
            if (at_zero) begin
                counter <= underflow_val;
                tc      <= 1'b1;
            end else begin
                counter <= counter - ONE;
                tc      <= 1'b0;
            end
        end else begin
            tc <= 1'b0;
        end
    end

endmodule

// File: tb/tb_down_counter_4bit.sv
// Directed bench for down_counter_4bit.
// Hand-computed vectors, checked 1 time unit after each rising edge.
module tb_down_counter_4bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       ld;
    logic [3:0] din;
    logic       mode;
    logic       bo;
    logic       tc;
    logic [3:0] counter;

    int checks   = 0;
    int failures = 0;

    down_counter_4bit #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .ld      (ld),
        .din     (din),
        .mode    (mode),
        .bo      (bo),
        .tc      (tc),
        .counter (counter)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input int c, input int t, input int b);
        chk({tag, ".counter"}, int'(counter), c);
        chk({tag, ".tc"},      int'(tc),      t);
        chk({tag, ".bo"},      int'(bo),      b);
    endtask

    int reload_cnt [6] = '{1, 0, 2, 1, 0, 2};
    int reload_tc  [6] = '{0, 0, 1, 0, 0, 1};

    initial begin
        rst = 1'b1; en = 1'b0; ld = 1'b0; din = '0; mode = 1'b0;

        // Reset wins over load and enable
        rst = 1'b0; ld = 1'b1; din = 4'd9; en = 1'b1;
        step();
        expect_state("reset", 0, 0, 1);

        // Load 3 then count down to 0
        rst = 1'b1; ld = 1'b1; din = 4'd3; en = 1'b0;
        step();
        expect_state("load3", 3, 0, 0);
        ld = 1'b0; en = 1'b1;
        step(); expect_state("cnt2", 2, 0, 0);
        step(); expect_state("cnt1", 1, 0, 0);
        step(); expect_state("cnt0", 0, 0, 1);

        // Wrap underflow
        mode = 1'b0;
        step(); expect_state("wrap", 15, 1, 0);
        en = 1'b0;
        step(); expect_state("wrap_hold", 15, 0, 0);

        // Auto-reload from 2
        ld = 1'b1; din = 4'd2; mode = 1'b1; en = 1'b1;
        step(); expect_state("load2", 2, 0, 0);
        ld = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            expect_state($sformatf("reload%0d", i), reload_cnt[i], reload_tc[i], int'(reload_cnt[i] == 0));
        end

        // Mode toggling mid-count has no effect
        mode = 1'b0;
        step(); expect_state("mode_mid1", 1, 0, 0);
        mode = 1'b1;
        step(); expect_state("mode_mid0", 0, 0, 1);

        // Load collides with underflow
        ld = 1'b1; din = 4'd7;
        step(); expect_state("collide", 7, 0, 0);

        // Mid-count reset
        din = 4'd5;
        step(); expect_state("load5", 5, 0, 0);
        ld = 1'b0;
        step(); expect_state("cnt4", 4, 0, 0);
        step(); expect_state("cnt3", 3, 0, 0);
        rst = 1'b0;
        step(); expect_state("midrst", 0, 0, 1);

        // Reload register cleared: reload of 0 pulses tc every edge
        rst = 1'b1; mode = 1'b1;
        step(); expect_state("rel0_a", 0, 1, 1);
        step(); expect_state("rel0_b", 0, 1, 1);
        en = 1'b0;
        step(); expect_state("rel0_hold", 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
